output_port: RTL
================

Name: output_port

Overview:
- Per-output-port stage between the crossbar and the outgoing link; one instance per router output port.
- Registers the crossbar flit onto the link.
- Synchronises the downstream input port's per-VC on/off and allocatable flags.
- Tracks ownership of each downstream VC with a small FSM, so the switch allocator and VC allocator see accurate availability.
- Raises sticky per-VC protocol errors.

Parameters:
- VC_NUM, from noc_params, default 2: virtual channels per port.
- RELEASE_DELAY, default 2: cycles a VC stays in WAIT after its tail before it may be reallocated.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- xb_flit_i  in  flit_t  flit from crossbar column
- xb_valid_i  in  1  xb_flit_i valid this cycle
- va_claim_i  in  VC_NUM  one-hot: VC allocator grants this downstream VC this cycle
- on_off_i  in  VC_NUM  downstream input port on/off per VC (1 = may send)
- vc_allocatable_i  in  VC_NUM  downstream input port allocatable flags
- data_o  out  flit_t  link flit
- valid_flit_o  out  1  link flit valid
- is_on_off_o  out  VC_NUM  registered on/off, to switch allocator
- is_allocatable_o  out  VC_NUM  to VC allocator
- error_o  out  VC_NUM  sticky per-VC protocol error

Behaviour:
- Reset (rst low, async):
  - data_o = 0, valid_flit_o = 0.
  - on/off and allocatable sync registers = all ones (downstream is empty after reset).
  - All VC FSMs = IDLE, release counters = 0, error_o = 0.
- Link path:
  - data_o and valid_flit_o register xb_flit_i and xb_valid_i every cycle; latency is exactly 1 cycle.
  - data_o is don't-care when valid_flit_o = 0, but it must hold 0 after reset.
- Sync:
  - on_sync and alloc_sync are 1-flop registers of on_off_i and vc_allocatable_i.
  - is_on_off_o = on_sync.
  - is_allocatable_o[v] = alloc_sync[v] AND (state[v] == IDLE).
- Per-VC FSM. Let v = xb_flit_i.vc_id; a flit event on v occurs when xb_valid_i = 1.
  - IDLE:
    - va_claim_i[v] with is_allocatable_o[v] = 1 -> RESERVED.
    - va_claim_i[v] with is_allocatable_o[v] = 0 -> error, stay IDLE.
  - RESERVED:
    - HEAD -> ACTIVE.
    - HEADTAIL -> WAIT.
    - BODY or TAIL -> error, stay.
  - ACTIVE:
    - BODY -> stay.
    - TAIL -> WAIT.
    - HEAD or HEADTAIL -> error, stay.
  - WAIT:
    - On entry the counter loads RELEASE_DELAY-1.
    - Counter decrements each cycle; at 0 -> IDLE.
    - RELEASE_DELAY = 1 gives exactly one cycle in WAIT.
  - A flit event on a VC in IDLE or WAIT -> error.
  - A claim on a VC not in IDLE -> error.
- Additional error: a flit event while on_sync[v] = 0 (downstream overflow risk) -> error_o[v].
- Flits are always forwarded to the link, including errored ones; an error never stalls the link path.
- error_o bits are sticky until reset.
- Simultaneous events:
  - Claim and flit on the same IDLE VC in one cycle: the claim is taken (-> RESERVED) and the flit flags an error.
  - Claims and flits on different VCs in one cycle are independent.
  - A va_claim_i that is not one-hot sets error on every claimed bit and changes no state.
- Counter width is clog2(RELEASE_DELAY+1).
- Asserting reset mid-packet returns all VCs to IDLE immediately; no flit is emitted on the next edge.

Decomposition:
- Shared in noc_params: flit_t, flit_label_t (HEAD/BODY/TAIL/HEADTAIL), VC_NUM, VC_SIZE.
- Local enum ovc_state_t {IDLE, RESERVED, ACTIVE, WAIT} lives in noc_params, for reuse by the allocators' assertions.
- One natural sub-module: output_vc_tracker. It holds the FSM, release counter and error bit for a single VC and is generated VC_NUM times. Flit routing and sync registers stay in output_port.

Test Plan:
- Reset: rst low with all inputs toggling -> valid_flit_o = 0, is_on_off_o = all ones, is_allocatable_o = all ones, error_o = 0.
- Normal packet on VC1:
  - va_claim_i = 2'b10 -> is_allocatable_o = 2'b01 next cycle.
  - HEAD, BODY, TAIL on vc_id 1 over 3 cycles -> each appears on data_o 1 cycle later.
  - is_allocatable_o[1] returns to 1 exactly RELEASE_DELAY cycles after the TAIL edge (2 by default).
  - error_o = 0 throughout.
- HEADTAIL on a RESERVED VC0 -> WAIT, then IDLE after 2 cycles; error_o = 0.
- Protocol errors:
  - BODY on an IDLE VC0 -> error_o = 2'b01 and the flit is still forwarded.
  - A second HEAD in ACTIVE sets the same VC's error bit.
  - Both errors persist until rst.
- Flow control: on_off_i[0] = 0 for 1 cycle, then a flit on VC0 the next cycle -> error_o[0] = 1. With on_off_i[0] = 0 and no flit on VC0, error_o stays 0.
- Claim/flit collision: va_claim_i = 2'b01 with a HEAD on VC0 in the same cycle -> state RESERVED, error_o[0] = 1. Asserting rst mid-packet -> all IDLE, is_allocatable_o = 2'b11 after release.

Source files
------------

// File: rtl/noc_params.sv
// Shared router types and sizing: flit layout, flit labels and the output-VC ownership states.
package noc_params;

  localparam int VC_NUM     = 2;
  localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [1:0] {IDLE, RESERVED, ACTIVE, WAIT} ovc_state_t;

  typedef struct packed {
    flit_label_t             flit_label;
    logic [VC_SIZE-1:0]      vc_id;
    logic [DATA_WIDTH-1:0]   data;
  } flit_t;

endpackage

// File: rtl/output_port_if.sv
// Bundle of crossbar, allocator and downstream-link signals seen by one router output port.
interface output_port_if;
  import noc_params::*;

  flit_t              xb_flit_i;
  logic               xb_valid_i;
  logic [VC_NUM-1:0]  va_claim_i;
  logic [VC_NUM-1:0]  on_off_i;
  logic [VC_NUM-1:0]  vc_allocatable_i;
  flit_t              data_o;
  logic               valid_flit_o;
  logic [VC_NUM-1:0]  is_on_off_o;
  logic [VC_NUM-1:0]  is_allocatable_o;
  logic [VC_NUM-1:0]  error_o;

  modport slave (
    input  xb_flit_i, xb_valid_i, va_claim_i, on_off_i, vc_allocatable_i,
    output data_o, valid_flit_o, is_on_off_o, is_allocatable_o, error_o
  );

  modport master (
    output xb_flit_i, xb_valid_i, va_claim_i, on_off_i, vc_allocatable_i,
    input  data_o, valid_flit_o, is_on_off_o, is_allocatable_o, error_o
  );

endinterface

// File: rtl/output_vc_tracker.sv
// Ownership FSM for a single downstream VC: claim, packet progress, release delay and a sticky error flag.
module output_vc_tracker
  import noc_params::*;
#(
  parameter int RELEASE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        claim_i,
  input  logic        claim_onehot_i,
  input  logic        flit_i,
  input  flit_label_t label_i,
  input  logic        on_i,
  input  logic        alloc_i,
  output logic        idle_o,
  output logic        error_o
);

  localparam int CNT_W = $clog2(RELEASE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_DELAY - 1);

  ovc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic             err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err     = 1'b0;

    if (state_q == WAIT) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end

    if (flit_i) begin
      if (!on_i) err = 1'b1;
      case (state_q)
        RESERVED: begin
          if (label_i == HEAD) begin
            state_d = ACTIVE;
          end else if (label_i == HEADTAIL) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            err = 1'b1;
          end
        end
        ACTIVE: begin
          if (label_i == TAIL) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else if (label_i != BODY) begin
            err = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
    end

    // A claim only ever succeeds from IDLE, so it cannot collide with a flit-driven transition.
    if (claim_i) begin
      if (!claim_onehot_i || state_q != IDLE || !alloc_i) err = 1'b1;
      else                                                state_d = RESERVED;
    end

    error_d = error_q | err;
  end

  assign idle_o  = (state_q == IDLE);
  assign error_o = error_q;

endmodule

// File: rtl/output_port.sv
// Router output port: registers crossbar flits onto the link, syncs downstream credits flags, tracks VC ownership.
module output_port
  import noc_params::*;
#(
  parameter int RELEASE_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  output_port_if.slave  bus
);

  flit_t             data_q;
  logic              valid_q;
  logic [VC_NUM-1:0] on_sync_q;
  logic [VC_NUM-1:0] alloc_sync_q;
  logic [VC_NUM-1:0] vc_idle;
  logic [VC_NUM-1:0] vc_error;
  logic              claim_onehot;

  // Downstream buffers are empty after reset, so every VC starts on and allocatable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      on_sync_q    <= '1;
      alloc_sync_q <= '1;
    end else begin
      data_q       <= bus.xb_flit_i;
      valid_q      <= bus.xb_valid_i;
      on_sync_q    <= bus.on_off_i;
      alloc_sync_q <= bus.vc_allocatable_i;
    end
  end

  assign claim_onehot = $onehot(bus.va_claim_i);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    output_vc_tracker #(
      .RELEASE_DELAY (RELEASE_DELAY)
    ) u_tracker (
      .clk            (clk),
      .rst            (rst),
      .claim_i        (bus.va_claim_i[v]),
      .claim_onehot_i (claim_onehot),
      .flit_i         (bus.xb_valid_i && (bus.xb_flit_i.vc_id == VC_SIZE'(v))),
      .label_i        (bus.xb_flit_i.flit_label),
      .on_i           (on_sync_q[v]),
      .alloc_i        (alloc_sync_q[v]),
      .idle_o         (vc_idle[v]),
      .error_o        (vc_error[v])
    );
  end

  assign bus.data_o           = data_q;
  assign bus.valid_flit_o     = valid_q;
  assign bus.is_on_off_o      = on_sync_q;
  assign bus.is_allocatable_o = alloc_sync_q & vc_idle;
  assign bus.error_o          = vc_error;

endmodule
